// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: datapath width, funct3 access-size codes, FSM states.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data
);
    logic [XLEN-1:0] shifted;

    // Halfword accesses are already known aligned, so one byte-granular shift serves both sizes.
    assign shifted = dmem_rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through or runs one load/store over a
// valid/ready data-memory port, producing a registered MEM/WB bundle.
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_fault
);
    state_t          state_q;
    logic            dmem_req_q, dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]      dmem_be_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic            wb_valid_q, wb_reg_write_q, mem_fault_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic [1:0]      addr_lo;
    logic            is_mem, f3_legal, misaligned, fault;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d, load_data;

    assign addr_lo = alu_result[1:0];
    assign is_mem  = mem_read | mem_write;

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:         f3_legal = 1'b1;
            F3_BU:        f3_legal = ~mem_write;
            F3_H:  begin  f3_legal = 1'b1;       misaligned = addr_lo[0];       end
            F3_HU: begin  f3_legal = ~mem_write; misaligned = addr_lo[0];       end
            F3_W:  begin  f3_legal = 1'b1;       misaligned = (addr_lo != 2'b00); end
            default:      f3_legal = 1'b0;
        endcase
    end

    assign fault = is_mem & (~f3_legal | misaligned);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        case (funct3[1:0])
            2'b00: begin be_d = 4'b0001 << addr_lo; wdata_d = {4{store_data[7:0]}};  end
            2'b01: begin be_d = 4'b0011 << addr_lo; wdata_d = {2{store_data[15:0]}}; end
            default: ;
        endcase
    end

    load_align u_load_align (
        .dmem_rdata (dmem_rdata),
        .addr_lo    (off_q),
        .funct3     (funct3_q),
        .load_data  (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_be_q      <= '0;
            dmem_wdata_q   <= '0;
            funct3_q       <= '0;
            off_q          <= '0;
            rd_q           <= '0;
            rw_q           <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            mem_fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem || fault) begin
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= rd;
                            wb_data_q      <= alu_result;
                            wb_reg_write_q <= ~is_mem & reg_write & (rd != 5'd0);
                            mem_fault_q    <= fault;
                        end else begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= mem_write;
                            dmem_addr_q  <= {alu_result[XLEN-1:2], 2'b00};
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
                            funct3_q     <= funct3;
                            off_q        <= addr_lo;
                            rd_q         <= rd;
                            rw_q         <= mem_read & reg_write & (rd != 5'd0);
                            state_q      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req_q     <= 1'b0;
                        state_q        <= IDLE;
                        wb_valid_q     <= 1'b1;
                        wb_rd_q        <= rd_q;
                        wb_reg_write_q <= rw_q;
                        mem_fault_q    <= 1'b0;
                        // Stores report their byte address, loads the extended data.
                        wb_data_q      <= dmem_we_q ? {dmem_addr_q[XLEN-1:2], off_q} : load_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == BUSY);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign mem_fault    = mem_fault_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expected values.
module tb_mem_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_stage dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd           (rd),
        .reg_write    (reg_write),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .mem_fault    (mem_fault)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] sd, input logic rdn,
                           input logic wrn, input logic [2:0] f3, input logic [4:0] r,
                           input logic rw);
        in_valid   = 1'b1;
        alu_result = a;
        store_data = sd;
        mem_read   = rdn;
        mem_write  = wrn;
        funct3     = f3;
        rd         = r;
        reg_write  = rw;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; rd = '0; reg_write = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        tick(); tick();
        check("rst_stall",    32'(stall), 32'd0);
        check("rst_req",      32'(dmem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data",  wb_data, 32'd0);
        check("rst_fault",    32'(mem_fault), 32'd0);
        reset = 1'b0;

        // Non-memory pass-through
        present(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        tick(); in_valid = 1'b0;
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_data",  wb_data, 32'h0000_1234);
        check("alu_wb_rw",    32'(wb_reg_write), 32'd1);
        check("alu_wb_rd",    32'(wb_rd), 32'd5);
        check("alu_stall",    32'(stall), 32'd0);
        tick();
        check("alu_pulse",    32'(wb_valid), 32'd0);
        check("alu_hold",     wb_data, 32'h0000_1234);

        // SB at 0x103, ready after 3 cycles of request
        present(32'h0000_0103, 32'hAABB_CCDD, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0);
        tick(); in_valid = 1'b0;
        check("sb_addr",  dmem_addr, 32'h0000_0100);
        check("sb_be",    32'(dmem_be), 32'h8);
        check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_we",    32'(dmem_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("sb_req",   32'(dmem_req), 32'd1);
            check("sb_stall", 32'(stall), 32'd1);
            check("sb_nowb",  32'(wb_valid), 32'd0);
            if (i == 2) dmem_ready = 1'b1;
            tick();
        end
        dmem_ready = 1'b0;
        check("sb_req_drop", 32'(dmem_req), 32'd0);
        check("sb_wb_valid", 32'(wb_valid), 32'd1);
        check("sb_wb_rw",    32'(wb_reg_write), 32'd0);
        check("sb_fault",    32'(mem_fault), 32'd0);

        // LB then LBU back-to-back at 0x202, ready held high
        dmem_rdata = 32'h0080_0000; dmem_ready = 1'b1;
        present(32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
        tick(); in_valid = 1'b0;
        check("lb_req", 32'(dmem_req), 32'd1);
        check("lb_be",  32'(dmem_be), 32'h4);
        check("lb_early", 32'(wb_valid), 32'd0);
        tick();
        check("lb_wb_valid", 32'(wb_valid), 32'd1);
        check("lb_wb_data",  wb_data, 32'hFFFF_FF80);
        check("lb_wb_rw",    32'(wb_reg_write), 32'd1);
        present(32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b100, 5'd8, 1'b1);
        tick(); in_valid = 1'b0;
        check("lbu_accept", 32'(dmem_req), 32'd1);
        tick();
        check("lbu_wb_valid", 32'(wb_valid), 32'd1);
        check("lbu_wb_data",  wb_data, 32'h0000_0080);
        check("lbu_wb_rd",    32'(wb_rd), 32'd8);

        // LH at 0x102 sign-extends the upper half
        dmem_rdata = 32'h8001_0000;
        present(32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b001, 5'd9, 1'b1);
        tick(); in_valid = 1'b0;
        check("lh_be", 32'(dmem_be), 32'hC);
        tick();
        check("lh_wb_data", wb_data, 32'hFFFF_8001);

        // SH replication at 0x202
        present(32'h0000_0202, 32'h1122_3344, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0);
        tick(); in_valid = 1'b0;
        check("sh_be",    32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'h3344_3344);
        tick();
        check("sh_wb_valid", 32'(wb_valid), 32'd1);
        dmem_ready = 1'b0;

        // Misaligned LW at 0x106
        present(32'h0000_0106, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
        tick(); in_valid = 1'b0;
        check("mis_req",      32'(dmem_req), 32'd0);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_fault",    32'(mem_fault), 32'd1);
        check("mis_wb_rw",    32'(wb_reg_write), 32'd0);
        check("mis_wb_data",  wb_data, 32'h0000_0106);
        check("mis_stall",    32'(stall), 32'd0);

        // Store with unsigned size is illegal
        present(32'h0000_0200, 32'h0, 1'b0, 1'b1, 3'b100, 5'd0, 1'b0);
        tick(); in_valid = 1'b0;
        check("sbu_req",   32'(dmem_req), 32'd0);
        check("sbu_fault", 32'(mem_fault), 32'd1);

        // Reset while BUSY abandons the access
        present(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1);
        tick(); in_valid = 1'b0;
        check("rb_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rb_req_low", 32'(dmem_req), 32'd0);
        check("rb_stall",   32'(stall), 32'd0);
        check("rb_wb",      32'(wb_valid), 32'd0);
        dmem_ready = 1'b1;
        tick();
        check("rb_no_wb",   32'(wb_valid), 32'd0);
        dmem_ready = 1'b0;
        present(32'h0000_0055, 32'h0, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1);
        tick(); in_valid = 1'b0;
        check("rb_add_valid", 32'(wb_valid), 32'd1);
        check("rb_add_data",  wb_data, 32'h0000_0055);
        check("rb_add_fault", 32'(mem_fault), 32'd0);

        // LW to x0 never writes back
        dmem_rdata = 32'hDEAD_BEEF; dmem_ready = 1'b1;
        present(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b010, 5'd0, 1'b1);
        tick(); in_valid = 1'b0;
        check("lw0_be", 32'(dmem_be), 32'hF);
        tick();
        check("lw0_wb_valid", 32'(wb_valid), 32'd1);
        check("lw0_wb_rw",    32'(wb_reg_write), 32'd0);
        check("lw0_wb_data",  wb_data, 32'hDEAD_BEEF);
        dmem_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage sitting directly downstream of the ALU. It consumes the registered ALU result as either a pass-through writeback value or a load/store address. It runs load/store accesses over a valid/ready data-memory handshake, including byte-lane alignment and sign/zero extension. It produces the registered MEM/WB bundle and stalls upstream while an access is outstanding.

## Interface
- No parameters; data width fixed at 32, register index 5 bits.
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream presents an instruction
- alu_result  in  32  ALU data_out: writeback value or memory address
- store_data  in  32  rs2 value for stores
- mem_read  in  1  load
- mem_write  in  1  store (mem_read and mem_write never both high)
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- stall  out  1  upstream must hold its outputs and in_valid
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (alu_result with [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  memory accepts the request; dmem_rdata valid in the same cycle for loads
- dmem_rdata  in  32  load word
- wb_valid  out  1  MEM/WB bundle valid, one cycle per instruction
- wb_rd  out  5
- wb_reg_write  out  1
- wb_data  out  32
- mem_fault  out  1  misaligned or illegal-funct3 access; accompanies wb_valid

## Operation
- FSM states: IDLE and BUSY. Acceptance occurs when in_valid is high and the state is IDLE. While BUSY, in_valid is ignored.
- Non-memory instruction: wb_valid=1 next cycle with wb_data=alu_result. The FSM stays IDLE.
- Fault check on acceptance (memory op only):
  - H/HU with addr[0]=1 is a fault.
  - W with addr[1:0]≠0 is a fault.
  - funct3 ∉ {000,001,010,100,101} is a fault. A store with 100/101 is also a fault.
  - On fault: no request is issued. Next cycle wb_valid=1, mem_fault=1, wb_reg_write=0, wb_data=alu_result.
- Good memory op: latch the request registers and go to BUSY.
  - dmem_req stays high with stable addr/be/wdata/we until dmem_ready is sampled high.
  - On that edge: dmem_req drops, state returns to IDLE, and wb_valid=1 in the following cycle.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<addr[1:0]
  - W: 1111
  - Loads drive dmem_be the same way.
- Store data replication:
  - B: {4{data[7:0]}}
  - H: {2{data[15:0]}}
  - W: data as is
- Load extract: select the byte or half selected by addr[1:0] from dmem_rdata. B/H are sign-extended; BU/HU are zero-extended.
- Stores complete with wb_reg_write=0.
- wb_reg_write is forced 0 whenever rd=0.
- dmem_ready while dmem_req=0 is ignored.

## Timing
- Reset (synchronous): state=IDLE. dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_reg_write, wb_data and mem_fault all go to 0.
- Reset while BUSY abandons the access. dmem_req is low after that edge and no wb_valid is produced.
- stall = (state==BUSY). It depends on registered state only and has no combinational path from in_valid or dmem_ready.
- Latency from the acceptance edge T:
  - Non-memory or fault: wb at T+1.
  - Memory op: dmem_req high at T+1; if ready is sampled at T+k, wb is at T+k+1. Minimum is 2 cycles.
- Back-to-back: an instruction presented in the cycle after wb_valid rises is accepted, because the state is already IDLE. There is no bubble beyond the memory wait.
- wb_valid is a one-cycle pulse. The wb_* fields hold their last values when wb_valid=0.

## Structure
- Shared package riscv_pkg holds:
  - funct3 size constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state enum (IDLE, BUSY).
  - XLEN=32.
- Sub-module load_align (combinational): inputs dmem_rdata, addr[1:0] and funct3; output is the extended 32-bit value. It is instantiated once.
- Fault detection, byte-enable generation and store replication stay inline.

## Test plan
- Non-memory pass-through: alu_result=0x0000_1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_reg_write=1, stall never asserted.
- SB with addr 0x103, store_data 0xAABBCCDD, dmem_ready delayed 3 cycles:
  - dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD.
  - dmem_req and stall high for 3 cycles, then wb_valid with wb_reg_write=0.
- LB vs LBU at addr 0x202, rdata=0x0080_0000, ready immediate → wb_data=0xFFFF_FF80 for LB and 0x0000_0080 for LBU, each 2 cycles after accept.
- Misaligned LW at 0x106 → no dmem_req; next cycle wb_valid=1, mem_fault=1, wb_reg_write=0.
- Reset during BUSY (before ready) → after the edge dmem_req=0, stall=0, wb_valid=0; a following ADD-type instruction completes normally.
- LW to rd=0, rdata=0xDEADBEEF → wb_reg_write=0, wb_data=0xDEADBEEF.
